// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg
// Shared definitions for the AES command sequencer: FSM state encoding,
// register word indices (byte address bits [5:2]) and CTRL/STATUS bit positions.
// No ports.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY_LOAD  = 3'd1,
        ST_KEY_WAIT  = 3'd2,
        ST_DATA_SEND = 3'd3,
        ST_DATA_WAIT = 3'd4
    } state_e;

    localparam logic [3:0] IDX_CTRL   = 4'd0;
    localparam logic [3:0] IDX_STATUS = 4'd1;
    localparam logic [3:0] IDX_KEY0   = 4'd4;
    localparam logic [3:0] IDX_DIN0   = 4'd8;
    localparam logic [3:0] IDX_DOUT0  = 4'd12;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_KEY_NEW = 1;
    localparam int CTRL_CLR_ERR = 2;
    localparam int CTRL_IRQ_ENA = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_KEY_VALID = 3;
    localparam int STAT_CNT_LSB   = 16;

endpackage

// File: rtl/aes_sched_regfile.sv
// aes_sched_regfile
// KEY/DIN/DOUT storage, write decode and the registered read mux.
// Ports:
//   clk, reset        block clock, async active-high reset
//   wr_en_i/addr/data register write strobe, byte address, data
//   busy_i            sequencer busy; KEY/DIN writes are dropped while set
//   dout_we_i, dout_i capture strobe and result block from the core
//   status_i          STATUS word assembled by the sequencer
//   rd_addr_i         read byte address
//   rd_data_o         read data, one cycle latency
//   key_wr_o          an accepted KEY write happened this cycle
//   key_o, din_o      128-bit key / plaintext, word 0 in bits [127:96]
module aes_sched_regfile
    import aes_sched_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [C_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [31:0]             wr_data_i,
    input  logic                    busy_i,
    input  logic                    dout_we_i,
    input  logic [127:0]            dout_i,
    input  logic [31:0]             status_i,
    input  logic [C_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [31:0]             rd_data_o,
    output logic                    key_wr_o,
    output logic [127:0]            key_o,
    output logic [127:0]            din_o
);

    logic [3:0][31:0] key_q;
    logic [3:0][31:0] din_q;
    logic [3:0][31:0] dout_q;
    logic [3:0]       wr_idx;
    logic [3:0]       rd_idx;
    logic             din_wr;
    logic [31:0]      rd_mux;
    logic             unused_addr_bits;

    assign wr_idx = wr_addr_i[5:2];
    assign rd_idx = rd_addr_i[5:2];

    // Only [5:2] select a register; the rest of the address is don't-care.
    assign unused_addr_bits = ^{wr_addr_i[C_ADDR_WIDTH-1:6], wr_addr_i[1:0],
                                rd_addr_i[C_ADDR_WIDTH-1:6], rd_addr_i[1:0]};

    assign key_wr_o = wr_en_i & ~busy_i & (wr_idx[3:2] == IDX_KEY0[3:2]);
    assign din_wr   = wr_en_i & ~busy_i & (wr_idx[3:2] == IDX_DIN0[3:2]);

    assign key_o = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign din_o = {din_q[0], din_q[1], din_q[2], din_q[3]};

    always_comb begin
        rd_mux = '0;
        case (rd_idx[3:2])
            2'b00:   rd_mux = (rd_idx == IDX_STATUS) ? status_i : '0;
            2'b01:   rd_mux = key_q[rd_idx[1:0]];
            2'b10:   rd_mux = din_q[rd_idx[1:0]];
            default: rd_mux = dout_q[rd_idx[1:0]];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            rd_data_o <= '0;
        end else begin
            if (key_wr_o) key_q[wr_idx[1:0]] <= wr_data_i;
            if (din_wr)   din_q[wr_idx[1:0]] <= wr_data_i;
            if (dout_we_i) begin
                dout_q[0] <= dout_i[127:96];
                dout_q[1] <= dout_i[95:64];
                dout_q[2] <= dout_i[63:32];
                dout_q[3] <= dout_i[31:0];
            end
            rd_data_o <= rd_mux;
        end
    end

endmodule

// File: rtl/aes_sched.sv
// aes_sched
// Command sequencer between the register port and the AES core. A GO write
// loads the key if needed, sends one block, waits for the result, latches it
// and updates done/err/key_valid/block_cnt. A wait-state counter aborts a hung core.
// Ports:
//   clk, reset                      clock, async active-high reset
//   reg_data_write/addr/reg_data    register write port
//   reg_rd_addr, reg_rd_data        register read port (1-cycle latency)
//   aes_key, aes_key_load           key and key-expansion start pulse
//   aes_key_ready                   core finished key expansion
//   aes_din, aes_din_valid/ready    plaintext block handshake
//   aes_dout, aes_dout_valid        result block, single-cycle valid
//   busy                            sequencer not idle
//   irq                             only with AES_SCHED_IRQ_EN defined
// Optional feature macro: AES_SCHED_IRQ_EN (CTRL bit3 IRQ_ENA and irq output).
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 10,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_W  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reg_data_write,
    input  logic [C_ADDR_WIDTH-1:0] reg_data_addr,
    input  logic [C_DATA_WIDTH-1:0] reg_data,
    input  logic [C_ADDR_WIDTH-1:0] reg_rd_addr,
    output logic [C_DATA_WIDTH-1:0] reg_rd_data,
    output logic [127:0]            aes_key,
    output logic                    aes_key_load,
    input  logic                    aes_key_ready,
    output logic [127:0]            aes_din,
    output logic                    aes_din_valid,
    input  logic                    aes_din_ready,
    input  logic [127:0]            aes_dout,
    input  logic                    aes_dout_valid,
    output logic                    busy
`ifdef AES_SCHED_IRQ_EN
    ,
    output logic                    irq
`endif
);

    state_e                 state_q, state_d;
    logic [C_TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   key_valid_q, key_valid_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   dout_we;
    logic                   key_wr;
    logic                   ctrl_wr;
    logic                   tmo_hit;
    logic [31:0]            status;

    assign ctrl_wr = reg_data_write & (reg_data_addr[5:2] == IDX_CTRL);
    assign tmo_hit = &tmo_q;

    assign aes_key_load  = (state_q == ST_KEY_LOAD);
    assign aes_din_valid = (state_q == ST_DATA_SEND);
    assign busy          = (state_q != ST_IDLE);

    assign status = {cnt_q, 12'h000, key_valid_q, err_q, done_q, busy};

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q + {{(C_TIMEOUT_W-1){1'b0}}, 1'b1};
        done_d      = done_q;
        err_d       = err_q;
        key_valid_d = key_valid_q;
        cnt_d       = cnt_q;
        dout_we     = 1'b0;

        // CLR_ERR lands before the GO check so CLR_ERR+GO restarts in one write.
        if (ctrl_wr && reg_data[CTRL_CLR_ERR]) err_d = 1'b0;
        if (key_wr) key_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (ctrl_wr && reg_data[CTRL_GO] && !err_d) begin
                    done_d  = 1'b0;
                    state_d = (reg_data[CTRL_KEY_NEW] || !key_valid_q) ? ST_KEY_LOAD : ST_DATA_SEND;
                end
            end
            ST_KEY_LOAD: begin
                tmo_d   = '0;
                state_d = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                if (aes_key_ready) begin
                    key_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_DATA_SEND;
                end else if (tmo_hit) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA_SEND: begin
                if (aes_din_ready) begin
                    tmo_d   = '0;
                    state_d = ST_DATA_WAIT;
                end else if (tmo_hit) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA_WAIT: begin
                if (aes_dout_valid) begin
                    dout_we = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            err_q       <= err_d;
            key_valid_q <= key_valid_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef AES_SCHED_IRQ_EN
    logic irq_ena_q, irq_ena_d, irq_q;

    assign irq_ena_d = ctrl_wr ? reg_data[CTRL_IRQ_ENA] : irq_ena_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_ena_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_ena_q <= irq_ena_d;
            irq_q     <= irq_ena_d & (done_d | err_d);
        end
    end

    assign irq = irq_q;
`endif

    aes_sched_regfile #(
        .C_ADDR_WIDTH(C_ADDR_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (reg_data_write),
        .wr_addr_i (reg_data_addr),
        .wr_data_i (reg_data),
        .busy_i    (busy),
        .dout_we_i (dout_we),
        .dout_i    (aes_dout),
        .status_i  (status),
        .rd_addr_i (reg_rd_addr),
        .rd_data_o (reg_rd_data),
        .key_wr_o  (key_wr),
        .key_o     (aes_key),
        .din_o     (aes_din)
    );

endmodule

// File: tb/tb_aes_sched.sv
module tb_aes_sched;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         reg_data_write;
    logic [9:0]   reg_data_addr;
    logic [31:0]  reg_data;
    logic [9:0]   reg_rd_addr;
    logic [31:0]  reg_rd_data;
    logic [127:0] aes_key;
    logic         aes_key_load;
    logic         aes_key_ready;
    logic [127:0] aes_din;
    logic         aes_din_valid;
    logic         aes_din_ready;
    logic [127:0] aes_dout;
    logic         aes_dout_valid;
    logic         busy;
`ifdef AES_SCHED_IRQ_EN
    logic         irq;
`endif

    always #5 clk = ~clk;

    aes_sched #(.C_ADDR_WIDTH(10), .C_DATA_WIDTH(32), .C_TIMEOUT_W(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .reg_data_write (reg_data_write),
        .reg_data_addr  (reg_data_addr),
        .reg_data       (reg_data),
        .reg_rd_addr    (reg_rd_addr),
        .reg_rd_data    (reg_rd_data),
        .aes_key        (aes_key),
        .aes_key_load   (aes_key_load),
        .aes_key_ready  (aes_key_ready),
        .aes_din        (aes_din),
        .aes_din_valid  (aes_din_valid),
        .aes_din_ready  (aes_din_ready),
        .aes_dout       (aes_dout),
        .aes_dout_valid (aes_dout_valid),
        .busy           (busy)
`ifdef AES_SCHED_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in cipher: the real FIPS-197 answer for the reference vector,
    // an arbitrary key-dependent mix for everything else.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] b);
        if (k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
        return {b[95:0], b[127:96]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // ---------------- core model ----------------
    logic [127:0] core_key, core_blk;
    bit  hang = 0, slow = 0;
    bit  kpend, opend;
    int  kdly, rdly, odly;
    int  key_loads = 0, blocks_in = 0;

    initial begin
        aes_key_ready = 0; aes_din_ready = 0; aes_dout_valid = 0; aes_dout = '0;
        kpend = 0; opend = 0; kdly = 0; rdly = 0; odly = 0;
        forever begin
            @(negedge clk);
            aes_key_ready = 0; aes_din_ready = 0; aes_dout_valid = 0;
            if (reset) begin
                kpend = 0; opend = 0; rdly = 0;
            end else begin
                if (opend) begin
                    if (odly == 0) begin
                        aes_dout_valid = 1; aes_dout = cipher(core_key, core_blk); opend = 0;
                    end else odly--;
                end
                if (kpend) begin
                    if (kdly == 0) begin aes_key_ready = 1; kpend = 0; end
                    else kdly--;
                end
                if (aes_key_load) begin
                    core_key = aes_key; key_loads++; kpend = 1; kdly = $urandom_range(0, 4);
                end
                if (!aes_din_valid) rdly = slow ? 30 : $urandom_range(0, 3);
                else if (rdly == 0) begin
                    aes_din_ready = 1; core_blk = aes_din; blocks_in++;
                    opend = !hang; odly = $urandom_range(0, 6);
                end else rdly--;
            end
        end
    end

    // ---------------- reference register model ----------------
    logic [31:0] mkey [4];
    logic [31:0] mdin [4];
    logic [31:0] mdout[4];
    bit mkv, merr, mdone;
    int mcnt;

    function automatic logic [31:0] exp_status();
        return {mcnt[15:0], 12'h000, mkv, merr, mdone, 1'b0};
    endfunction

    function automatic logic [127:0] mkey128();
        return {mkey[0], mkey[1], mkey[2], mkey[3]};
    endfunction

    function automatic logic [127:0] mdin128();
        return {mdin[0], mdin[1], mdin[2], mdin[3]};
    endfunction

    // Idle-time write as seen by the model: words 4..7 key, 8..11 din.
    task automatic model_wr(input logic [9:0] a, input logic [31:0] v);
        int idx;
        idx = int'(a[5:2]);
        if (idx >= 4 && idx <= 7) begin mkey[idx-4] = v; mkv = 0; end
        else if (idx >= 8 && idx <= 11) mdin[idx-8] = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [9:0] a, input logic [31:0] v);
        @(negedge clk);
        reg_data_write = 1; reg_data_addr = a; reg_data = v;
        @(negedge clk);
        reg_data_write = 0;
    endtask

    task automatic rd_reg(input logic [9:0] a, output logic [31:0] v);
        @(negedge clk);
        reg_rd_addr = a;
        @(negedge clk);
        v = reg_rd_data;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic run_block(input logic [31:0] ctrl, input string tag);
        int kl0;
        bit exp_load;
        logic [127:0] r;
        logic [31:0] d;
        kl0 = key_loads;
        exp_load = ctrl[1] || !mkv;
        wr_reg(10'h000, ctrl);
        chk({tag, "_key_load"}, {31'b0, aes_key_load}, {31'b0, exp_load});
        chk({tag, "_din_valid"}, {31'b0, aes_din_valid}, {31'b0, !exp_load});
        wait_idle(2000);
        mdone = 1; mkv = 1; merr = 0; mcnt++;
        r = cipher(mkey128(), mdin128());
        for (int i = 0; i < 4; i++) mdout[i] = r[127-32*i -: 32];
        chk({tag, "_loads"}, key_loads - kl0, {31'b0, exp_load});
        for (int i = 0; i < 4; i++) begin
            rd_reg(10'(32'h30 + 4*i), d);
            chk({tag, "_dout"}, d, mdout[i]);
        end
        rd_reg(10'h004, d);
        chk({tag, "_status"}, d, exp_status());
    endtask

    typedef struct {
        bit          wr;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [9:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] d, old, ctrl;
        logic [9:0]  a;
        int c, g, b0, kl0, idx, nw;

        reset = 1; reg_data_write = 0; reg_data_addr = '0; reg_data = '0; reg_rd_addr = '0;
        for (int i = 0; i < 4; i++) begin mkey[i] = 0; mdin[i] = 0; mdout[i] = 0; end
        mkv = 0; merr = 0; mdone = 0; mcnt = 0;
        repeat (3) @(negedge clk);
        reset = 0;

        // reset state
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_key_load", {31'b0, aes_key_load}, 0);
        chk("rst_din_valid", {31'b0, aes_din_valid}, 0);
        rd_reg(10'h004, d); chk("rst_status", d, 0);
        rd_reg(10'h010, d); chk("rst_key0", d, 0);
        rd_reg(10'h03C, d); chk("rst_dout3", d, 0);

        // register map table
        tbl[0]  = '{1, 10'h010, 32'h00010203, 10'h010, 32'h00010203};
        tbl[1]  = '{1, 10'h014, 32'h04050607, 10'h014, 32'h04050607};
        tbl[2]  = '{1, 10'h018, 32'h08090a0b, 10'h3D8, 32'h08090a0b};
        tbl[3]  = '{1, 10'h01C, 32'h0c0d0e0f, 10'h01C, 32'h0c0d0e0f};
        tbl[4]  = '{1, 10'h020, 32'h00112233, 10'h020, 32'h00112233};
        tbl[5]  = '{1, 10'h3E4, 32'h44556677, 10'h024, 32'h44556677};
        tbl[6]  = '{1, 10'h028, 32'h8899aabb, 10'h028, 32'h8899aabb};
        tbl[7]  = '{1, 10'h02C, 32'hccddeeff, 10'h02F, 32'hccddeeff};
        tbl[8]  = '{1, 10'h008, 32'hdeadbeef, 10'h008, 32'h00000000};
        tbl[9]  = '{1, 10'h030, 32'h12345678, 10'h030, 32'h00000000};
        tbl[10] = '{0, 10'h000, 32'h00000000, 10'h000, 32'h00000000};
        tbl[11] = '{1, 10'h004, 32'hffffffff, 10'h004, 32'h00000000};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin wr_reg(tbl[i].waddr, tbl[i].wdata); model_wr(tbl[i].waddr, tbl[i].wdata); end
            rd_reg(tbl[i].raddr, d);
            chk($sformatf("tbl%0d", i), d, tbl[i].exp);
        end

        // FIPS-197 vector
        run_block(32'h1, "fips");
        rd_reg(10'h030, d); chk("fips_ct0", d, 32'h69c4e0d8);
        rd_reg(10'h03C, d); chk("fips_ct3", d, 32'h70b4c55a);
        rd_reg(10'h004, d); chk("fips_stat", d, 32'h0001000A);

        // second GO, key unchanged: no reload
        run_block(32'h1, "go2");
        rd_reg(10'h004, d); chk("go2_stat", d, 32'h0002000A);

        // writes and GO while busy are ignored
        slow = 1; old = mdin[0]; b0 = blocks_in;
        wr_reg(10'h000, 32'h1);
        wr_reg(10'h020, 32'hffffffff);
        wr_reg(10'h000, 32'h1);
        chk("busy_during", {31'b0, busy}, 1);
        wait_idle(2000);
        mdone = 1; mcnt++;
        repeat (3) @(negedge clk);
        chk("busy_after", {31'b0, busy}, 0);
        chk("busy_blocks", blocks_in - b0, 1);
        rd_reg(10'h020, d); chk("busy_din0", d, old);
        rd_reg(10'h004, d); chk("busy_status", d, exp_status());
        slow = 0;

        // hung core -> timeout
        hang = 1;
        wr_reg(10'h000, 32'h1);
        c = 0; g = 0;
        while (busy && g < 6000) begin
            if (!aes_din_valid) c++;
            @(negedge clk); g++;
        end
        n_checks++;
        if (c < 4095 || c > 4096) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d cycles in wait, expected 4095..4096", c);
        end
        hang = 0;
        mdone = 0; merr = 1; mkv = 0;
        rd_reg(10'h004, d); chk("tmo_status", d, exp_status());
        rd_reg(10'h030, d); chk("tmo_dout0", d, mdout[0]);
        wr_reg(10'h000, 32'h1);
        chk("err_go_ignored", {31'b0, busy}, 0);
        rd_reg(10'h004, d); chk("err_go_status", d, exp_status());
        run_block(32'h5, "clr_go");

        // randomized blocks
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                idx = $urandom_range(4, 11);
                a = 10'(($urandom_range(0, 15) << 6) | (idx << 2));
                d = $urandom;
                wr_reg(a, d);
                model_wr(a, d);
            end
            idx = $urandom_range(4, 11);
            rd_reg(10'(idx << 2), d);
            chk("rnd_readback", d, (idx < 8) ? mkey[idx-4] : mdin[idx-8]);
            ctrl = 32'h1 | ($urandom_range(0, 1) << 1) | ($urandom_range(0, 1) << 2);
            run_block(ctrl, "rnd");
        end

        // reset in the middle of DATA_SEND
        slow = 1; kl0 = key_loads;
        wr_reg(10'h000, 32'h1);
        g = 0;
        while (!aes_din_valid && g < 100) begin @(negedge clk); g++; end
        chk("pre_rst_din_valid", {31'b0, aes_din_valid}, 1);
        #1 reset = 1;
        #1;
        chk("async_rst_din_valid", {31'b0, aes_din_valid}, 0);
        chk("async_rst_busy", {31'b0, busy}, 0);
        chk("async_rst_key_load", {31'b0, aes_key_load}, 0);
        repeat (2) @(negedge clk);
        reset = 0; slow = 0;
        for (int i = 0; i < 4; i++) begin mkey[i] = 0; mdin[i] = 0; mdout[i] = 0; end
        mkv = 0; merr = 0; mdone = 0; mcnt = 0;
        chk("rst_no_key_load", key_loads - kl0, 0);
        rd_reg(10'h004, d); chk("post_rst_status", d, exp_status());
        rd_reg(10'h010, d); chk("post_rst_key0", d, 0);
        rd_reg(10'h020, d); chk("post_rst_din0", d, 0);
        rd_reg(10'h030, d); chk("post_rst_dout0", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
